// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment readback path: digit patterns, capture states, error bits.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment patterns for BCD 0..9, bit0 = segment a ... bit6 = segment g, active-high
    localparam logic [6:0] SEG7_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Per-digit capture state
    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_QUAL = 2'd1,
        CAP_HELD = 2'd2
    } cap_state_t;

    // Bit positions inside err_code
    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_OVERLAP = 1;

endpackage

// File: rtl/seg7_decode.sv
// Pattern to BCD decoder: inverse of the 7-segment encoder; unknown patterns flagged illegal.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic       legal,
    output logic [3:0] bcd
);

    // Match against the ten legal glyphs; all-zero and partial glyphs fall through as illegal
    always_comb begin
        legal = 1'b0;
        bcd   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pat == SEG7_DIGIT[i]) begin
                legal = 1'b1;
                bcd   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_mux_capture.sv
// Receive side of a 2-digit multiplexed 7-seg display: synchronise, qualify, decode to BCD.
// Latency: update pulses SYNC_STAGES + STABLE_CNT + 1 cycles after a stable pattern hits the pins.
// Backpressure: none; pins are sampled every cycle and outputs are plain registers.
module seg7_mux_capture
    import seg7_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CNT    = 4,
    parameter int BLANK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_pin,
    input  logic [1:0] dig_pin,
    input  logic       seg_inv,
    input  logic       dig_inv,
    input  logic       err_clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tens_blank,
    output logic       valid,
    output logic       update,
    output logic [1:0] err_code
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam int BLK_W = $clog2(BLANK_TIMEOUT + 1);
    // The sample that takes cnt from STABLE_CNT-1 to STABLE_CNT is the accepting one
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLANK_MAX = BLK_W'(BLANK_TIMEOUT);
    localparam logic [BLK_W-1:0] BLK_ONE   = BLK_W'(1);

    // Synchroniser chains
    logic [6:0] seg_sync_q [SYNC_STAGES];
    logic [6:0] seg_sync_d [SYNC_STAGES];
    logic [1:0] dig_sync_q [SYNC_STAGES];
    logic [1:0] dig_sync_d [SYNC_STAGES];

    // Per-digit capture machines: index 0 = ones, 1 = tens
    cap_state_t       st_q  [2];
    cap_state_t       st_d  [2];
    logic [6:0]       pat_q [2];
    logic [6:0]       pat_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       cap;

    // Output-side state
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic             blank_q, blank_d;
    logic             valid_q, valid_d;
    logic             update_q, update_d;
    logic [1:0]       err_q, err_d;
    logic [8:0]       prev_q, prev_d;
    logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;

    logic [6:0] seg;
    logic [1:0] dig;
    logic       overlap;
    logic       legal_ones, legal_tens;
    logic [3:0] bcd_ones, bcd_tens;
    logic [1:0] err_new;

    // Polarity is applied only after synchronisation so the chains carry raw pin levels
    assign seg     = seg_sync_q[SYNC_STAGES-1] ^ {7{seg_inv}};
    assign dig     = dig_sync_q[SYNC_STAGES-1] ^ {2{dig_inv}};
    assign overlap = dig[0] & dig[1];

    // Decode the latched pattern; at capture time it equals the live pattern
    seg7_decode u_dec_ones (.pat(pat_q[0]), .legal(legal_ones), .bcd(bcd_ones));
    seg7_decode u_dec_tens (.pat(pat_q[1]), .legal(legal_tens), .bcd(bcd_tens));

    // Shift the pins through the synchroniser chains
    always_comb begin
        seg_sync_d[0] = seg_pin;
        dig_sync_d[0] = dig_pin;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            seg_sync_d[i] = seg_sync_q[i-1];
            dig_sync_d[i] = dig_sync_q[i-1];
        end
    end

    // Capture FSMs: latch a pattern, count identical samples, accept once per enable window
    always_comb begin
        cap = 2'b00;
        for (int d = 0; d < 2; d++) begin
            st_d[d]  = st_q[d];
            pat_d[d] = pat_q[d];
            cnt_d[d] = cnt_q[d];
            if (overlap) begin
                // Both enables together: the sample is untrustworthy, restart both digits
                st_d[d]  = CAP_IDLE;
                cnt_d[d] = '0;
            end else begin
                unique case (st_q[d])
                    CAP_IDLE: begin
                        if (dig[d]) begin
                            st_d[d]  = CAP_QUAL;
                            pat_d[d] = seg;
                            cnt_d[d] = CNT_ONE;
                        end
                    end
                    CAP_QUAL: begin
                        if (!dig[d]) begin
                            st_d[d]  = CAP_IDLE;
                            cnt_d[d] = '0;
                        end else if (seg != pat_q[d]) begin
                            // Pattern moved: restart qualification on the new pattern
                            pat_d[d] = seg;
                            cnt_d[d] = CNT_ONE;
                        end else if (cnt_q[d] == CNT_LAST) begin
                            st_d[d]  = CAP_HELD;
                            cnt_d[d] = '0;
                            cap[d]   = 1'b1;
                        end else begin
                            cnt_d[d] = cnt_q[d] + CNT_ONE;
                        end
                    end
                    CAP_HELD: begin
                        if (!dig[d]) begin
                            st_d[d] = CAP_IDLE;
                        end
                    end
                    default: begin
                        st_d[d]  = CAP_IDLE;
                        cnt_d[d] = '0;
                    end
                endcase
            end
        end
    end

    // Digit registers, tens blanking, sticky errors and change detection
    always_comb begin
        ones_d  = ones_q;
        tens_d  = tens_q;
        blank_d = blank_q;
        valid_d = valid_q;
        err_new = 2'b00;

        if (dig[1]) begin
            blank_cnt_d = '0;
        end else if (blank_cnt_q == BLANK_MAX) begin
            blank_cnt_d = blank_cnt_q;
        end else begin
            blank_cnt_d = blank_cnt_q + BLK_ONE;
        end

        if (blank_cnt_q == BLANK_MAX) begin
            blank_d = 1'b1;
            tens_d  = 4'd0;
        end

        if (cap[0]) begin
            if (legal_ones) begin
                ones_d  = bcd_ones;
                valid_d = 1'b1;
            end else begin
                err_new[ERR_ILLEGAL] = 1'b1;
            end
        end

        if (cap[1]) begin
            if (legal_tens) begin
                tens_d  = bcd_tens;
                blank_d = 1'b0;
            end else begin
                err_new[ERR_ILLEGAL] = 1'b1;
            end
        end

        if (overlap) begin
            err_new[ERR_OVERLAP] = 1'b1;
        end

        // A fresh error beats a simultaneous clear
        err_d = (err_clr ? 2'b00 : err_q) | err_new;

        // Pulse one cycle after the visible outputs change value
        prev_d   = {blank_q, tens_q, ones_q};
        update_d = (prev_q != {blank_q, tens_q, ones_q});
    end

    // State registers; reset values match the idle display (tens blank, nothing captured)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= '0;
                dig_sync_q[i] <= '0;
            end
            for (int d = 0; d < 2; d++) begin
                st_q[d]  <= CAP_IDLE;
                pat_q[d] <= '0;
                cnt_q[d] <= '0;
            end
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            blank_q     <= 1'b1;
            valid_q     <= 1'b0;
            update_q    <= 1'b0;
            err_q       <= 2'b00;
            prev_q      <= 9'h100;
            blank_cnt_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                seg_sync_q[i] <= seg_sync_d[i];
                dig_sync_q[i] <= dig_sync_d[i];
            end
            for (int d = 0; d < 2; d++) begin
                st_q[d]  <= st_d[d];
                pat_q[d] <= pat_d[d];
                cnt_q[d] <= cnt_d[d];
            end
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            blank_q     <= blank_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            err_q       <= err_d;
            prev_q      <= prev_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign ones       = ones_q;
    assign tens       = tens_q;
    assign tens_blank = blank_q;
    assign valid      = valid_q;
    assign update     = update_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_seg7_mux_capture.sv
// Directed bench for seg7_mux_capture: table of display windows plus hand-written corner sequences.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Expected values are hand-derived from the digit table and the qualification rules.
module tb_seg7_mux_capture;

    localparam int SYNC    = 2;
    localparam int STABLE  = 4;
    localparam int BLANK   = 1024;
    localparam int LAT     = SYNC + STABLE + 1;
    localparam int GAP     = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_pin = 7'h00;
    logic [1:0] dig_pin = 2'b00;
    logic       seg_inv = 1'b0;
    logic       dig_inv = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] ones, tens;
    logic       tens_blank, valid, update;
    logic [1:0] err_code;

    int n_chk = 0;
    int n_err = 0;

    seg7_mux_capture #(
        .SYNC_STAGES(SYNC), .STABLE_CNT(STABLE), .BLANK_TIMEOUT(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .seg_pin(seg_pin), .dig_pin(dig_pin),
        .seg_inv(seg_inv), .dig_inv(dig_inv), .err_clr(err_clr),
        .ones(ones), .tens(tens), .tens_blank(tens_blank), .valid(valid),
        .update(update), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic [6:0] pat;
        int         hold;
        int         e_ones;
        int         e_tens;
        int         e_blank;
        int         e_err;
        int         e_upd;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ones"},  int'(ones), 0);
        chk({tag, " tens"},  int'(tens), 0);
        chk({tag, " blank"}, int'(tens_blank), 1);
        chk({tag, " valid"}, int'(valid), 0);
        chk({tag, " update"}, int'(update), 0);
        chk({tag, " err"},   int'(err_code), 0);
    endtask

    // Drive one enable window (polarity applied here), then idle for gap cycles.
    // Counts update pulses and records the rising edge (1-based) of the first one.
    task automatic run_window(input logic [1:0] en, input logic [6:0] pat, input int hold,
                              input int gap, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        @(negedge clk);
        dig_pin = en ^ {2{dig_inv}};
        seg_pin = pat ^ {7{seg_inv}};
        for (int i = 1; i <= hold + gap; i++) begin
            @(posedge clk);
            #1;
            if (update) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == hold) begin
                @(negedge clk);
                dig_pin = {2{dig_inv}};
            end
        end
    endtask

    task automatic count_idle(input int cycles, inout int pulses);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (update) pulses++;
        end
    endtask

    initial begin
        int p, fe, tot;

        tbl[0]  = '{2'b01, 7'h5B, 20, 2, 0, 1, 0, 1};
        tbl[1]  = '{2'b01, 7'h4F,  8, 3, 0, 1, 0, 1};
        tbl[2]  = '{2'b01, 7'h66,  8, 4, 0, 1, 0, 1};
        tbl[3]  = '{2'b01, 7'h6D,  8, 5, 0, 1, 0, 1};
        tbl[4]  = '{2'b01, 7'h7D,  8, 6, 0, 1, 0, 1};
        tbl[5]  = '{2'b01, 7'h07,  8, 7, 0, 1, 0, 1};
        tbl[6]  = '{2'b01, 7'h7F,  8, 8, 0, 1, 0, 1};
        tbl[7]  = '{2'b01, 7'h6F,  8, 9, 0, 1, 0, 1};
        tbl[8]  = '{2'b01, 7'h06,  8, 1, 0, 1, 0, 1};
        tbl[9]  = '{2'b01, 7'h3F,  8, 0, 0, 1, 0, 1};
        tbl[10] = '{2'b01, 7'h3F,  8, 0, 0, 1, 0, 0};  // same value again: no pulse
        tbl[11] = '{2'b10, 7'h6F,  8, 0, 9, 0, 0, 1};  // tens 9, blank drops in the same cycle
        tbl[12] = '{2'b10, 7'h06,  8, 0, 1, 0, 0, 1};
        tbl[13] = '{2'b01, 7'h6F,  8, 9, 1, 0, 0, 1};
        tbl[14] = '{2'b01, 7'h7F,  3, 9, 1, 0, 0, 0};  // 3 samples < STABLE_CNT: discarded

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven windows
        for (int k = 0; k < 15; k++) begin
            run_window(tbl[k].en, tbl[k].pat, tbl[k].hold, GAP, p, fe);
            chk($sformatf("vec%0d ones", k),   int'(ones),       tbl[k].e_ones);
            chk($sformatf("vec%0d tens", k),   int'(tens),       tbl[k].e_tens);
            chk($sformatf("vec%0d blank", k),  int'(tens_blank), tbl[k].e_blank);
            chk($sformatf("vec%0d err", k),    int'(err_code),   tbl[k].e_err);
            chk($sformatf("vec%0d valid", k),  int'(valid),      1);
            chk($sformatf("vec%0d pulses", k), p,                tbl[k].e_upd);
            if (tbl[k].e_upd == 1)
                chk($sformatf("vec%0d latency", k), fe, LAT);
        end

        // Multiplexed frames: tens already 1, ones moves 9 -> 8 once, re-captures stay silent
        tot = 0;
        for (int f = 0; f < 10; f++) begin
            run_window(2'b10, 7'h06, 16, 0, p, fe);
            tot += p;
            run_window(2'b01, 7'h7F, 16, 0, p, fe);
            tot += p;
        end
        chk("frames ones", int'(ones), 8);
        chk("frames tens", int'(tens), 1);
        chk("frames blank", int'(tens_blank), 0);
        chk("frames pulses", tot, 1);

        // Tens blanking: still shown well before the timeout, blank after it
        tot = 0;
        count_idle(900, tot);
        chk("pre-timeout blank", int'(tens_blank), 0);
        count_idle(200, tot);
        chk("timeout blank", int'(tens_blank), 1);
        chk("timeout tens", int'(tens), 0);
        chk("timeout ones", int'(ones), 8);
        chk("timeout pulses", tot, 1);

        // Illegal pattern held long enough to be accepted
        run_window(2'b01, 7'h49, 10, GAP, p, fe);
        chk("illegal err", int'(err_code), 1);
        chk("illegal ones", int'(ones), 8);
        chk("illegal pulses", p, 0);

        // Overlap arriving in the same cycle as err_clr: bit0 clears, bit1 wins
        @(negedge clk);
        dig_pin = 2'b11;
        seg_pin = 7'h00;
        @(negedge clk);
        dig_pin = 2'b00;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr vs overlap err", int'(err_code), 2);
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", int'(err_code), 0);

        // Overlap inside a ones QUAL window: no capture, then a clean window captures
        tot = 0;
        @(negedge clk);
        dig_pin = 2'b01;
        seg_pin = 7'h06;
        count_idle(2, tot);
        @(negedge clk);
        dig_pin = 2'b11;
        @(negedge clk);
        dig_pin = 2'b01;
        count_idle(1, tot);
        @(negedge clk);
        dig_pin = 2'b00;
        count_idle(GAP, tot);
        chk("overlap err", int'(err_code), 2);
        chk("overlap ones", int'(ones), 8);
        chk("overlap pulses", tot, 0);
        run_window(2'b01, 7'h06, 8, GAP, p, fe);
        chk("post-overlap ones", int'(ones), 1);
        chk("post-overlap pulses", p, 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Reset mid-QUAL, then re-acquire a 0 (same as reset value: no pulse)
        @(negedge clk);
        dig_pin = 2'b01;
        seg_pin = 7'h3F;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("mid-qual rst");
        @(negedge clk);
        rst = 1'b0;
        tot = 0;
        count_idle(10, tot);
        @(negedge clk);
        dig_pin = 2'b00;
        count_idle(GAP, tot);
        chk("rst reacq ones", int'(ones), 0);
        chk("rst reacq valid", int'(valid), 1);
        chk("rst reacq pulses", tot, 0);
        chk("rst reacq err", int'(err_code), 0);

        // Inverted polarity. Changing the straps leaves cleared synchroniser flops that read
        // as both enables active for a couple of cycles, so clear that error before checking.
        @(negedge clk);
        rst     = 1'b1;
        seg_inv = 1'b1;
        dig_inv = 1'b1;
        dig_pin = 2'b11;
        seg_pin = 7'h7F;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("inv settle err", int'(err_code), 0);
        run_window(2'b01, 7'h66, 8, GAP, p, fe);
        chk("inv ones", int'(ones), 4);
        chk("inv err", int'(err_code), 0);
        chk("inv pulses", p, 1);
        chk("inv latency", fe, LAT);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
